gpsdo_loop_filter: RTL
======================

// Module: gpsdo_loop_filter
// PURPOSE
//  PI loop filter for the GPSDO. Consumes one signed frequency-error sample per 1PPS gate
//  and produces the 16-bit OCXO tuning word for the AD5683 SPI driver downstream.
//  The driver transmits whenever its input word changes.
//  dac_code therefore changes only on a committed update and is otherwise held stable.
// PARAMETERS
//  ERR_W       32        width of signed error sample
//  ACC_W       40        width of signed integrator / sum datapath
//  KP_SHL      4         proportional gain, left shift applied to err
//  KI_SHL      0         integral gain, left shift applied to err before accumulation
//  OUT_SHR     4         arithmetic right shift of (P+I) before adding to DAC_INIT
//  INT_LIM     2**24     integrator clamp magnitude (anti-windup), |integ| <= INT_LIM
//  DAC_INIT    16'h8000  reset / centre tuning word
//  OUTLIER_MAX 100000    |err| above this is rejected as a glitch
//  LOCK_TOL    2         |err| <= LOCK_TOL counts toward lock
//  LOCK_N      8         consecutive in-tolerance samples required to assert locked
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-high reset
//  err_valid  in   1      1-cycle strobe, err is valid
//  err        in   ERR_W  signed error; positive raises dac_code
//  hold       in   1      freeze loop: samples ignored, integrator and dac_code held
//  dac_code   out  16     tuning word to SPI driver
//  dac_upd    out  1      1-cycle pulse when dac_code is committed
//  locked     out  1      loop lock indicator
//  busy       out  1      high while a sample is being processed (state != IDLE)
// BEHAVIOUR
//  - Reset (async, rst=1): dac_code=DAC_INIT, integ=0, lock_cnt=0, locked=0,
//    dac_upd=0, busy=0, state=IDLE.
//  - FSM states:
//    IDLE -(err_valid & !hold)-> CHECK -> INTEG -> SUM -> SAT -> UPD -> IDLE.
//  - IDLE: latch err into e_r. err_valid during hold or while busy is dropped, not queued.
//  - CHECK: if |e_r| > OUTLIER_MAX, clear lock_cnt and locked, then return to IDLE.
//    No update and no dac_upd in that case.
//    Otherwise, if |e_r| <= LOCK_TOL, lock_cnt increments and saturates at LOCK_N;
//    else lock_cnt clears.
//  - INTEG: integ <= clamp(integ + sext(e_r)<<<KI_SHL, -INT_LIM, +INT_LIM).
//  - SUM: s <= (integ + sext(e_r)<<<KP_SHL) >>> OUT_SHR (arithmetic), computed in ACC_W bits.
//  - SAT: c <= DAC_INIT + s, saturated to [0, 65535]. No wrap-around ever.
//  - UPD: dac_code <= c; dac_upd=1 for this cycle; locked <= (lock_cnt==LOCK_N).
//  - Latency: err_valid in cycle N -> dac_upd high in cycle N+5, with dac_code new the same cycle.
//  - dac_code changes only in UPD. This holds even if c equals the old value:
//    dac_upd still pulses and the driver sees no change.
//  - hold asserted mid-processing: the current sample completes; subsequent samples are ignored.
//    hold does not clear lock state.
//  - rst mid-processing: immediate return to reset values; no partial update is visible.
//  - All intermediate arithmetic is sign-extended to ACC_W.
//    The KP_SHL/KI_SHL shifts must not overflow ACC_W for |err| <= OUTLIER_MAX.
// STRUCTURE
//  - Shared include gpsdo_defs.vh holds:
//    - DAC_MIN = 0, DAC_MAX = 65535, DAC_W = 16;
//    - FSM state encodings (3-bit);
//    - DAC_INIT default.
//  - One sub-module, gpsdo_sat_add: parameterised signed add with clamp to [lo, hi].
//    It is instanced twice: integrator clamp and DAC range clamp.
// TESTING (defaults)
//  1 Reset -> dac_code=32768, locked=0, dac_upd=0; hold rst high across a clock edge,
//    outputs remain constant.
//  2 err=16 -> dac_upd 5 cycles later, dac_code=32785; err=16 again -> 32786;
//    then err=0 -> 32770.
//  3 err=100000 from reset -> sum saturates, dac_code=65535.
//    err=-100000 repeated x4 -> dac_code=0, never wraps.
//  4 err=1000000 (outlier) -> no dac_upd, dac_code unchanged, lock_cnt cleared.
//  5 8 consecutive err=1 -> locked=1 on 8th dac_upd; next err=3 -> locked=0.
//  6 hold=1 then err=16 -> no update; err_valid while busy -> dropped.
//    rst asserted in SUM -> dac_code=32768 immediately.

Source files
------------

// File: rtl/gpsdo_loop_filter_pkg.sv
// Shared constants for the GPSDO loop filter: DAC range, FSM state encodings
// and the centre tuning word.
package gpsdo_loop_filter_pkg;

  localparam int          DAC_W        = 16;
  localparam int          DAC_MIN      = 0;
  localparam int          DAC_MAX      = 65535;
  localparam logic [15:0] DAC_INIT_DEF = 16'h8000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_INTEG = 3'd2;
  localparam logic [2:0] S_SUM   = 3'd3;
  localparam logic [2:0] S_SAT   = 3'd4;
  localparam logic [2:0] S_UPD   = 3'd5;

endpackage

// File: rtl/gpsdo_sat_add.sv
// Signed W-bit add with the result clamped to [lo, hi]; the sum is formed one
// bit wider so the clamp never sees a wrapped value.
module gpsdo_sat_add #(
  parameter int W = 40
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] lo,
  input  logic signed [W-1:0] hi,
  output logic signed [W-1:0] y
);

  logic signed [W:0] a_x, b_x, lo_x, hi_x, sum;

  assign a_x  = {a[W-1], a};
  assign b_x  = {b[W-1], b};
  assign lo_x = {lo[W-1], lo};
  assign hi_x = {hi[W-1], hi};
  assign sum  = a_x + b_x;

  always_comb begin
    y = sum[W-1:0];
    if (sum > hi_x)      y = hi;
    else if (sum < lo_x) y = lo;
  end

endmodule

// File: rtl/gpsdo_loop_filter.sv
// PI loop filter: one signed frequency-error sample per 1PPS gate in, one
// committed 16-bit OCXO tuning word out five cycles later.
module gpsdo_loop_filter
  import gpsdo_loop_filter_pkg::*;
#(
  parameter int          ERR_W       = 32,
  parameter int          ACC_W       = 40,
  parameter int          KP_SHL      = 4,
  parameter int          KI_SHL      = 0,
  parameter int          OUT_SHR     = 4,
  parameter longint      INT_LIM     = 64'sd16777216,
  parameter logic [15:0] DAC_INIT    = DAC_INIT_DEF,
  parameter longint      OUTLIER_MAX = 64'sd100000,
  parameter longint      LOCK_TOL    = 64'sd2,
  parameter int          LOCK_N      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    err_valid,
  input  logic signed [ERR_W-1:0] err,
  input  logic                    hold,
  output logic [DAC_W-1:0]        dac_code,
  output logic                    dac_upd,
  output logic                    locked,
  output logic                    busy
);

  localparam int LCW = $clog2(LOCK_N + 1);

  logic [2:0]              state_q, state_d;
  logic signed [ERR_W-1:0] e_r_q, e_r_d;
  logic signed [ACC_W-1:0] integ_q, integ_d;
  logic signed [ACC_W-1:0] s_q, s_d;
  logic [DAC_W-1:0]        dac_code_q, dac_code_d;
  logic                    dac_upd_q, dac_upd_d;
  logic                    locked_q, locked_d;
  logic [LCW-1:0]          lock_cnt_q, lock_cnt_d;

  logic signed [ACC_W-1:0] e_ext, ki_term, kp_term, s_nxt;
  logic signed [ACC_W-1:0] int_lim_p, int_lim_n, integ_sat;
  logic signed [ACC_W-1:0] dac_base, dac_lo, dac_hi, dac_sat;
  logic signed [ACC_W-1:0] ol_p, ol_n, tol_p, tol_n;
  logic                    outlier, in_tol;
  logic                    unused_dac_hi_bits;

  assign e_ext     = {{(ACC_W-ERR_W){e_r_q[ERR_W-1]}}, e_r_q};
  assign ki_term   = e_ext <<< KI_SHL;
  assign kp_term   = e_ext <<< KP_SHL;
  assign s_nxt     = (integ_q + kp_term) >>> OUT_SHR;

  assign int_lim_p = ACC_W'(INT_LIM);
  assign int_lim_n = -int_lim_p;
  assign dac_base  = ACC_W'({1'b0, DAC_INIT});
  assign dac_lo    = ACC_W'(DAC_MIN);
  assign dac_hi    = ACC_W'(DAC_MAX);
  assign ol_p      = ACC_W'(OUTLIER_MAX);
  assign ol_n      = -ol_p;
  assign tol_p     = ACC_W'(LOCK_TOL);
  assign tol_n     = -tol_p;

  assign outlier   = (e_ext > ol_p) || (e_ext < ol_n);
  assign in_tol    = (e_ext <= tol_p) && (e_ext >= tol_n);

  // Anti-windup clamp on the integrator.
  gpsdo_sat_add #(.W(ACC_W)) u_integ_clamp (
    .a  (integ_q),
    .b  (ki_term),
    .lo (int_lim_n),
    .hi (int_lim_p),
    .y  (integ_sat)
  );

  // Keeps the tuning word inside the DAC range instead of wrapping.
  gpsdo_sat_add #(.W(ACC_W)) u_dac_clamp (
    .a  (dac_base),
    .b  (s_q),
    .lo (dac_lo),
    .hi (dac_hi),
    .y  (dac_sat)
  );

  assign unused_dac_hi_bits = ^dac_sat[ACC_W-1:DAC_W];

  always_comb begin
    state_d    = state_q;
    e_r_d      = e_r_q;
    integ_d    = integ_q;
    s_d        = s_q;
    dac_code_d = dac_code_q;
    dac_upd_d  = 1'b0;
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (err_valid && !hold) begin
          e_r_d   = err;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (outlier) begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
          state_d    = S_IDLE;
        end else begin
          if (!in_tol)                         lock_cnt_d = '0;
          else if (lock_cnt_q != LCW'(LOCK_N)) lock_cnt_d = lock_cnt_q + LCW'(1);
          state_d = S_INTEG;
        end
      end
      S_INTEG: begin
        integ_d = integ_sat;
        state_d = S_SUM;
      end
      S_SUM: begin
        s_d     = s_nxt;
        state_d = S_SAT;
      end
      // Commit on the SAT->UPD edge so the new word and dac_upd appear together in UPD.
      S_SAT: begin
        dac_code_d = dac_sat[DAC_W-1:0];
        dac_upd_d  = 1'b1;
        locked_d   = (lock_cnt_q == LCW'(LOCK_N));
        state_d    = S_UPD;
      end
      S_UPD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      e_r_q      <= '0;
      integ_q    <= '0;
      s_q        <= '0;
      dac_code_q <= DAC_INIT;
      dac_upd_q  <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      e_r_q      <= e_r_d;
      integ_q    <= integ_d;
      s_q        <= s_d;
      dac_code_q <= dac_code_d;
      dac_upd_q  <= dac_upd_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign dac_code = dac_code_q;
  assign dac_upd  = dac_upd_q;
  assign locked   = locked_q;
  assign busy     = (state_q != S_IDLE);

endmodule
